// File: rtl/tag_uart_pkg.sv
// Shared UART receive types and constants for the tag board serial taps.
package tag_uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned BT_CLKS_PER_BIT = 5208;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/tag_sync_fifo.sv
// Show-ahead synchronous FIFO with registered head; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module tag_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     refused_c
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_inc;
  logic [CNT_W-1:0] count_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push    = push && (!full || rd_en);
  assign do_pop     = rd_en && !empty;
  assign refused_c  = push && full && !rd_en;
  assign rd_ptr_inc = rd_ptr + AW'(1);

  // Occupancy and the head entry as they will look after this edge.
  always_comb begin
    count_nxt = count;
    head_nxt  = rd_data;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
    if (do_pop) begin
      if (count > CNT_W'(1)) begin
        head_nxt = mem[rd_ptr_inc];
      end else if (do_push) begin
        head_nxt = wdata;
      end
    end else if (do_push && empty) begin
      head_nxt = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      rd_data <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      count   <= count_nxt;
      empty   <= (count_nxt == '0);
      full    <= (count_nxt == CNT_W'(DEPTH));
      rd_data <= head_nxt;
    end
  end

endmodule

// File: rtl/bt_uart_rx_tap.sv
// Passive 8N1 receiver on the Bluetooth serial line; buffers bytes for fabric
// consumers and flags framing errors and FIFO overruns.
module bt_uart_rx_tap
  import tag_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = BT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [UART_DATA_BITS-1:0]     rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int unsigned CYC_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [CYC_W-1:0] HALF_LAST = CYC_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CYC_W-1:0] BIT_LAST  = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(UART_DATA_BITS - 1);

  uart_rx_state_t            state;
  logic                      rx_meta;
  logic                      rx_sync;
  logic [CYC_W-1:0]          cyc_cnt;
  logic [BIT_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic                      push_c;
  logic                      refused_c;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
    end
  end

  // Push happens in the stop-bit sample cycle so the byte shows one cycle later.
  assign push_c = (state == STOP) && (cyc_cnt == BIT_LAST) && rx_sync;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= refused_c;
      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state   <= START;
            cyc_cnt <= '0;
          end
        end
        START: begin
          if (cyc_cnt == HALF_LAST) begin
            cyc_cnt <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? IDLE : DATA;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        DATA: begin
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt   <= '0;
            shift_reg <= {rx_sync, shift_reg[UART_DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
            end
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        STOP: begin
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt <= '0;
            if (rx_sync) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        BREAK: begin
          if (rx_sync) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  tag_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (push_c),
    .wdata     (shift_reg),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .refused_c (refused_c)
  );

endmodule

// File: tb/tb_bt_uart_rx_tap.sv
// Directed bench for bt_uart_rx_tap at 16 clocks/bit with a 4-entry FIFO.
module tb_bt_uart_rx_tap;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       frame_err;
  logic       overrun;

  int total  = 0;
  int passed = 0;
  int fe_total = 0;
  int ov_total = 0;

  typedef struct {
    logic [7:0] tx;
    logic       stop_ok;
    logic [7:0] exp_data;
    logic       exp_empty;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];

  bt_uart_rx_tap #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .rxd           (rxd),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .frame_err     (frame_err),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_total = fe_total + 1;
    if (overrun)   ov_total = ov_total + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end else begin
      passed = passed + 1;
    end
  endtask

  // Start bit begins at the first negedge; returns after stop_cycles of stop level.
  task automatic drive_frame(input logic [7:0] d, input int stop_cycles, input logic stop_val);
    @(negedge clk); rxd = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); rxd = d[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk); rxd = stop_val;
    repeat (stop_cycles - 1) @(negedge clk);
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] exp);
    chk(nm, 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_data"},   32'(rd_data),   32'h0);
    chk({tag, "_empty"},     32'(empty),     32'h1);
    chk({tag, "_full"},      32'(full),      32'h0);
    chk({tag, "_count"},     32'(count),     32'h0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    chk({tag, "_overrun"},   32'(overrun),   32'h0);
  endtask

  initial begin
    int fe0;
    int ov0;
    rxd   = 1'b1;
    rd_en = 1'b0;
    rst_n = 1'b0;

    vecs[0] = '{tx: 8'h00, stop_ok: 1'b1, exp_data: 8'h00, exp_empty: 1'b0, exp_fe: 0};
    vecs[1] = '{tx: 8'hFF, stop_ok: 1'b1, exp_data: 8'hFF, exp_empty: 1'b0, exp_fe: 0};
    vecs[2] = '{tx: 8'h3C, stop_ok: 1'b0, exp_data: 8'h00, exp_empty: 1'b1, exp_fe: 1};
    vecs[3] = '{tx: 8'h55, stop_ok: 1'b1, exp_data: 8'h55, exp_empty: 1'b0, exp_fe: 0};
    vecs[4] = '{tx: 8'h80, stop_ok: 1'b1, exp_data: 8'h80, exp_empty: 1'b0, exp_fe: 0};
    vecs[5] = '{tx: 8'h96, stop_ok: 1'b1, exp_data: 8'h96, exp_empty: 1'b0, exp_fe: 0};

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte with exact push latency: sample at edge 155 after the start negedge.
    drive_frame(8'hA5, 11, 1'b1);
    chk("a5_empty_before_push", 32'(empty), 32'h1);
    @(negedge clk);
    chk("a5_empty_after_push", 32'(empty), 32'h0);
    chk("a5_count", 32'(count), 32'h1);
    repeat (5) @(negedge clk);
    pop_chk("a5_rd_data", 8'hA5);
    chk("a5_empty_after_pop", 32'(empty), 32'h1);
    chk("a5_count_after_pop", 32'(count), 32'h0);

    // Glitch shorter than half a bit.
    fe0 = fe_total;
    @(negedge clk); rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_empty", 32'(empty), 32'h1);
    chk("glitch_frame_err", 32'(fe_total - fe0), 32'h0);

    // Table of single frames, each popped after checking.
    for (int v = 0; v < 6; v++) begin
      fe0 = fe_total;
      drive_frame(vecs[v].tx, CPB, vecs[v].stop_ok);
      rxd = 1'b1;
      repeat (4) @(negedge clk);
      chk($sformatf("vec%0d_empty", v), 32'(empty), 32'(vecs[v].exp_empty));
      chk($sformatf("vec%0d_count", v), 32'(count), vecs[v].exp_empty ? 32'h0 : 32'h1);
      chk($sformatf("vec%0d_frame_err", v), 32'(fe_total - fe0), 32'(vecs[v].exp_fe));
      if (!vecs[v].exp_empty) begin
        pop_chk($sformatf("vec%0d_rd_data", v), vecs[v].exp_data);
        chk($sformatf("vec%0d_empty_after_pop", v), 32'(empty), 32'h1);
      end
    end

    // Long break: one frame_err only, then a clean frame.
    fe0 = fe_total;
    drive_frame(8'h3C, 40, 1'b0);
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    chk("break_frame_err_count", 32'(fe_total - fe0), 32'h1);
    chk("break_fifo_empty", 32'(empty), 32'h1);
    drive_frame(8'h11, CPB, 1'b1);
    repeat (2) @(negedge clk);
    chk("after_break_count", 32'(count), 32'h1);
    pop_chk("after_break_rd_data", 8'h11);

    // Overrun: fifth byte dropped.
    ov0 = ov_total;
    for (int b = 1; b <= 4; b++) drive_frame(8'(b), CPB, 1'b1);
    chk("ovr_full_after_4", 32'(full), 32'h1);
    chk("ovr_count_after_4", 32'(count), 32'h4);
    drive_frame(8'h05, 11, 1'b1);
    @(negedge clk);
    chk("ovr_pulse", 32'(overrun), 32'h1);
    @(negedge clk);
    chk("ovr_pulse_ends", 32'(overrun), 32'h0);
    repeat (4) @(negedge clk);
    chk("ovr_pulse_total", 32'(ov_total - ov0), 32'h1);
    chk("ovr_count_kept", 32'(count), 32'h4);
    for (int b = 1; b <= 4; b++) pop_chk($sformatf("ovr_pop%0d", b), 8'(b));
    chk("ovr_empty_end", 32'(empty), 32'h1);

    // Full FIFO with a pop in the push cycle.
    ov0 = ov_total;
    for (int b = 1; b <= 4; b++) drive_frame(8'(b), CPB, 1'b1);
    drive_frame(8'h05, 11, 1'b1);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("simul_no_overrun", 32'(overrun), 32'h0);
    chk("simul_count", 32'(count), 32'h4);
    chk("simul_full", 32'(full), 32'h1);
    repeat (4) @(negedge clk);
    chk("simul_overrun_total", 32'(ov_total - ov0), 32'h0);
    for (int b = 2; b <= 5; b++) pop_chk($sformatf("simul_pop%0d", b), 8'(b));
    chk("simul_empty_end", 32'(empty), 32'h1);

    // Reset during data bit 4 of a partial frame, with a byte already buffered.
    drive_frame(8'h5A, CPB, 1'b1);
    chk("pre_reset_count", 32'(count), 32'h1);
    @(negedge clk); rxd = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rxd = 1'b0;
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk); rxd = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    rxd   = 1'b1;
    @(negedge clk);
    chk_reset_vals("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_empty", 32'(empty), 32'h1);
    drive_frame(8'h7E, CPB, 1'b1);
    repeat (2) @(negedge clk);
    chk("post_reset_count", 32'(count), 32'h1);
    pop_chk("post_reset_rd_data", 8'h7E);
    chk("post_reset_empty_end", 32'(empty), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
